// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer slice.
//   state_t            : sequencer FSM states
//   DIR_LEFT/DIR_RIGHT : shift direction encodings
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/bidir_shift_core.sv
// Bidirectional N-bit shift register with parallel load.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : load_data -> q this edge (wins over shift_en)
//   load_data  : parallel load value
//   shift_en   : perform one single-bit shift this edge
//   dir        : DIR_LEFT (ser_in -> bit0) / DIR_RIGHT (ser_in -> bit N-1)
//   ser_in     : bit shifted in
//   q          : register contents
module bidir_shift_core
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         shift_en,
    input  logic         dir,
    input  logic         ser_in,
    output logic [N-1:0] q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_data;
        end else if (shift_en) begin
            if (dir == DIR_RIGHT) begin
                r_q <= {ser_in, r_q[N-1:1]};
            end else begin
                r_q <= {r_q[N-2:0], ser_in};
            end
        end
    end

    assign q = r_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a bidirectional shift register.
// One command per cmd_valid/cmd_ready handshake: optional load, direction and
// a shift count (clamped to N); shifts then run one per clock, bits stream out
// on ser_out, and done pulses once on completion. abort cancels a running
// command, leaving the partially shifted contents in place.
//
//   state | meaning
//   IDLE  | ready for a command
//   SHIFT | one shift per edge until the counter reaches zero
//   DONE  | one-cycle completion pulse, no handshake accepted
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   cmd_valid/cmd_ready             : command handshake
//   cmd_load, cmd_data              : optional parallel load at handshake
//   cmd_dir, cmd_count              : direction, number of shifts
//   abort                           : cancel command while shifting
//   ser_in / ser_out                : serial in, outgoing bit (combinational)
//   shift_active, busy, done        : status
//   data_out                        : register contents
module shift_sequencer #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [N-1:0]     cmd_data,
    input  logic             abort,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             shift_active,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     data_out
);

    import shift_pkg::*;

    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [CNT_W-1:0] w_cnt_clamp;
    logic             w_hs;
    logic             w_dir_eff;
    logic [N-1:0]     w_q;

    assign w_cnt_clamp = (cmd_count > N_CNT) ? N_CNT : cmd_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        cmd_ready    = 1'b0;
        shift_active = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        w_hs         = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                w_hs      = cmd_valid;
                if (cmd_valid) begin
                    w_state_nxt = (w_cnt_clamp != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                // an aborting cycle performs no shift, so it is not "active"
                shift_active = ~abort;
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // remaining-shift down-counter and latched direction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_dir <= DIR_LEFT;
        end else if (w_hs) begin
            r_cnt <= w_cnt_clamp;
            r_dir <= cmd_dir;
        end else if (r_state == SHIFT) begin
            if (abort) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    bidir_shift_core #(.N(N)) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (w_hs & cmd_load),
        .load_data (cmd_data),
        .shift_en  (shift_active),
        .dir       (r_dir),
        .ser_in    (ser_in),
        .q         (w_q)
    );

    // in IDLE the latched dir is stale; preview the bit for the offered command
    assign w_dir_eff = (r_state == IDLE) ? cmd_dir : r_dir;
    assign ser_out   = (w_dir_eff == DIR_RIGHT) ? w_q[0] : w_q[N-1];
    assign data_out  = w_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_load;
    logic          cmd_dir;
    logic [CW-1:0] cmd_count;
    logic [N-1:0]  cmd_data;
    logic          abort;
    logic          ser_in;
    logic          ser_out;
    logic          shift_active;
    logic          busy;
    logic          done;
    logic [N-1:0]  data_out;

    int n_chk  = 0;
    int n_pass = 0;
    int model  = 0;   // expected register value as a plain integer 0..255

    shift_sequencer #(.N(N), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_load     (cmd_load),
        .cmd_dir      (cmd_dir),
        .cmd_count    (cmd_count),
        .cmd_data     (cmd_data),
        .abort        (abort),
        .ser_in       (ser_in),
        .ser_out      (ser_out),
        .shift_active (shift_active),
        .busy         (busy),
        .done         (done),
        .data_out     (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_out(input int v, input bit dir);
        return dir ? (v % 2) : ((v / 128) % 2);
    endfunction

    task automatic run_cmd(input bit ld, input int d, input bit dir, input int cnt,
                           input int sin_mode, input int abort_at,
                           output int seq, output int nshift);
        int eff;
        int sb;
        seq    = 0;
        nshift = 0;
        chk("idle_ready", int'(cmd_ready), 1);
        chk("idle_busy", int'(busy), 0);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_data  = d[7:0];
        cmd_dir   = dir;
        cmd_count = cnt[3:0];
        #1;
        chk("idle_ser_out", int'(ser_out), exp_out(model, dir));
        tick;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_data  = 8'($urandom_range(0, 255));
        if (ld) model = d;
        eff = (cnt > N) ? N : cnt;
        for (int i = 0; i < eff; i++) begin
            if (i == abort_at) begin
                abort = 1'b1;
                #1;
                chk("abort_no_shift", int'(shift_active), 0);
                tick;
                abort = 1'b0;
                chk("abort_busy", int'(busy), 0);
                chk("abort_ready", int'(cmd_ready), 1);
                chk("abort_done", int'(done), 0);
                chk("abort_data", int'(data_out), model);
                return;
            end
            sb     = (sin_mode == 2) ? int'($urandom_range(0, 1)) : sin_mode;
            ser_in = 1'(sb);
            #1;
            chk("shift_active", int'(shift_active), 1);
            chk("shift_done", int'(done), 0);
            chk("shift_data", int'(data_out), model);
            chk("shift_ser_out", int'(ser_out), exp_out(model, dir));
            seq = seq * 2 + int'(ser_out);
            nshift++;
            tick;
            model = dir ? (model / 2 + sb * 128) : ((model * 2 + sb) % 256);
        end
        chk("done_pulse", int'(done), 1);
        chk("done_ready", int'(cmd_ready), 0);
        chk("done_active", int'(shift_active), 0);
        chk("done_data", int'(data_out), model);
        chk("done_ser_out", int'(ser_out), exp_out(model, dir));
        // offer a command during DONE: it must not be taken
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_data  = 8'(255 - model);
        cmd_count = 4'd0;
        tick;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        chk("post_done", int'(done), 0);
        chk("post_ready", int'(cmd_ready), 1);
        chk("post_busy", int'(busy), 0);
        chk("post_data", int'(data_out), model);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seq, ns, eff, ab, gap;
        bit ld, dir;
        int d, cnt;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_dir   = 1'b0;
        cmd_count = '0;
        cmd_data  = '0;
        abort     = 1'b0;
        ser_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_data", int'(data_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_active", int'(shift_active), 0);

        // 1: full left shift of A5
        run_cmd(1'b1, 'hA5, 1'b0, 8, 0, -1, seq, ns);
        chk("t1_seq", seq, 'hA5);
        chk("t1_nshift", ns, 8);
        chk("t1_data", int'(data_out), 0);

        // 2: right shift of 81 by 3 with ones in
        run_cmd(1'b1, 'h81, 1'b1, 3, 1, -1, seq, ns);
        chk("t2_seq", seq, 4);
        chk("t2_data", int'(data_out), 'hF0);

        // 3: zero count
        run_cmd(1'b1, 'h3C, 1'b0, 0, 0, -1, seq, ns);
        chk("t3_nshift", ns, 0);
        chk("t3_data", int'(data_out), 'h3C);

        // 4: count clamps to N
        run_cmd(1'b1, 'hFF, 1'b0, 15, 0, -1, seq, ns);
        chk("t4_nshift", ns, 8);
        chk("t4_data", int'(data_out), 0);

        // 5: abort after two shifts
        run_cmd(1'b1, 'h0F, 1'b0, 8, 1, 2, seq, ns);
        chk("t5_data", int'(data_out), 'h3F);

        // 6: reset (with abort) mid-shift
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_data  = 8'hA5;
        cmd_dir   = 1'b0;
        cmd_count = 4'd8;
        tick;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        ser_in    = 1'b1;
        tick;
        tick;
        chk("t6_pre_busy", int'(busy), 1);
        reset = 1'b1;
        abort = 1'b1;
        tick;
        reset = 1'b0;
        abort = 1'b0;
        model = 0;
        chk("t6_data", int'(data_out), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_ready", int'(cmd_ready), 1);
        for (int i = 0; i < 10; i++) begin
            chk("t6_no_done", int'(done), 0);
            tick;
        end

        // randomized commands with idle gaps and occasional aborts
        for (int k = 0; k < 60; k++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                tick;
                chk("gap_ready", int'(cmd_ready), 1);
                chk("gap_data", int'(data_out), model);
            end
            ld  = 1'($urandom_range(0, 1));
            dir = 1'($urandom_range(0, 1));
            d   = int'($urandom_range(0, 255));
            cnt = int'($urandom_range(0, 15));
            eff = (cnt > N) ? N : cnt;
            ab  = -1;
            if (eff > 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(0, eff - 1));
            run_cmd(ld, d, dir, cnt, 2, ab, seq, ns);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
